// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that feeds fixed-length character messages
// from NREQ sources, one message at a time, into a single character-level UART transmitter.
module uart_tx_sched #(
    parameter int         NREQ      = 4,
    parameter int         MSG_LEN   = 2,
    parameter bit         ADD_TERM  = 1'b1,
    parameter logic [6:0] TERM_CHAR = 7'h0D
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*MSG_LEN*7-1:0] msg_data,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic [6:0]                tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      sched_busy,
    output logic [2:0]                cur_id
);

    localparam int NCHAR = MSG_LEN + (ADD_TERM ? 1 : 0);
    localparam int MSG_W = MSG_LEN * 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_SKIP  = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_ptr;
    logic [2:0]       r_sel;
    logic [3:0]       r_cnt;
    logic [MSG_W-1:0] r_buf;
    logic [6:0]       r_tx_data;
    logic [2:0]       w_arb_sel;
    logic             w_arb_hit;
    logic [6:0]       w_char;
    logic             w_last;

    // Cyclic search from r_ptr; scanning downwards lets the lowest offset win.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_sel = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % NREQ]) begin
                w_arb_hit = 1'b1;
                w_arb_sel = 3'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_char = TERM_CHAR;
        if (int'(r_cnt) < MSG_LEN) begin
            w_char = r_buf[int'(r_cnt) * 7 +: 7];
        end
    end

    assign w_last = (int'(r_cnt) + 1 >= NCHAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_hit) w_state_nxt = S_ISSUE;
            S_ISSUE: if (!tx_busy) w_state_nxt = S_SKIP;
            S_SKIP:  w_state_nxt = S_WAIT;
            S_WAIT:  if (!tx_busy) w_state_nxt = w_last ? S_FIN : S_ISSUE;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        done       = '0;
        cur_id     = 3'd0;
        tx_start   = 1'b0;
        tx_data    = r_tx_data;
        sched_busy = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                gnt      = {{(NREQ-1){1'b0}}, 1'b1} << r_sel;
                cur_id   = r_sel;
                tx_start = !tx_busy;
                if (!tx_busy) tx_data = w_char;
            end
            S_SKIP, S_WAIT: begin
                gnt    = {{(NREQ-1){1'b0}}, 1'b1} << r_sel;
                cur_id = r_sel;
            end
            S_FIN:   done = {{(NREQ-1){1'b0}}, 1'b1} << r_sel;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= 3'd0;
            r_cnt     <= 4'd0;
            r_tx_data <= 7'd0;
        end else begin
            if (r_state == S_IDLE && w_arb_hit) r_cnt <= 4'd0;
            if (r_state == S_WAIT && !tx_busy) r_cnt <= r_cnt + 4'd1;
            if (tx_start) r_tx_data <= w_char;
            if (r_state == S_FIN) begin
                r_ptr <= (int'(r_sel) == NREQ - 1) ? 3'd0 : r_sel + 3'd1;
            end
        end
    end

    // Message snapshot at grant time; later msg_data changes are not seen.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_arb_hit) begin
            r_sel <= w_arb_sel;
            r_buf <= msg_data[int'(w_arb_sel) * MSG_W +: MSG_W];
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: randomized messages and transmitter
// busy times checked against a round-robin reference model.
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int MSG_LEN = 2;
    localparam int MW      = NREQ * MSG_LEN * 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [MW-1:0]   msg;
    logic [NREQ-1:0] gnt, done;
    logic [6:0]      tx_data;
    logic            tx_start, tx_busy, sched_busy;
    logic [2:0]      cur_id;

    logic [NREQ-1:0] req6;
    logic [27:0]     msg6;
    logic [NREQ-1:0] gnt6, done6;
    logic [6:0]      tx_data6;
    logic            tx_start6, tx_busy6, sched_busy6;
    logic [2:0]      cur_id6;

    int n_tests = 0;
    int n_fail  = 0;
    int n_busy_viol = 0;
    int n_done_gnt  = 0;
    int busy_min = 2;
    int busy_var = 0;
    int busy_cnt = 0;
    int busy6_cnt = 0;

    logic [6:0]      q_chars[$];
    int              q_gnt[$];
    int              q_done[$];
    logic [NREQ-1:0] prev_gnt = '0;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(NREQ), .MSG_LEN(MSG_LEN), .ADD_TERM(1'b1), .TERM_CHAR(7'h0D)) dut (
        .clk(clk), .rst(rst), .req(req), .msg_data(msg), .gnt(gnt), .done(done),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .sched_busy(sched_busy), .cur_id(cur_id)
    );

    uart_tx_sched #(.NREQ(NREQ), .MSG_LEN(1), .ADD_TERM(1'b0), .TERM_CHAR(7'h0D)) dut6 (
        .clk(clk), .rst(rst), .req(req6), .msg_data(msg6), .gnt(gnt6), .done(done6),
        .tx_data(tx_data6), .tx_start(tx_start6), .tx_busy(tx_busy6),
        .sched_busy(sched_busy6), .cur_id(cur_id6)
    );

    // Transmitter models: busy from the cycle after tx_start for a random length.
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= busy_min + int'($urandom_range(0, busy_var));
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (tx_start6) busy6_cnt <= 3;
        else if (busy6_cnt > 0) busy6_cnt <= busy6_cnt - 1;
    end
    assign tx_busy  = (busy_cnt != 0);
    assign tx_busy6 = (busy6_cnt != 0);

    always @(negedge clk) begin
        if (tx_start) begin
            q_chars.push_back(tx_data);
            if (tx_busy) n_busy_viol++;
        end
        if (done != '0) begin
            for (int i = 0; i < NREQ; i++) if (done[i]) q_done.push_back(i);
            if (gnt != '0) n_done_gnt++;
        end
        if (gnt != '0 && prev_gnt == '0) q_gnt.push_back(int'(cur_id));
        prev_gnt = gnt;
    end

    task automatic clear_logs();
        q_chars.delete();
        q_gnt.delete();
        q_done.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req6 = '0; msg = '0; msg6 = '0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (gnt !== 4'b0000 || done !== 4'b0000) begin
                n_fail++; $display("FAIL reset_gnt_done: got gnt=%b done=%b expected 0000/0000", gnt, done);
            end
            n_tests++;
            if (sched_busy !== 1'b0 || cur_id !== 3'd0 || tx_start !== 1'b0 || tx_data !== 7'd0) begin
                n_fail++; $display("FAIL reset_outputs: got busy=%b id=%0d start=%b data=%h expected 0/0/0/00",
                                   sched_busy, cur_id, tx_start, tx_data);
            end
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_tests++;
            if (tx_start !== 1'b0 || gnt !== 4'b0000 || sched_busy !== 1'b0 || cur_id !== 3'd0) begin
                n_fail++; $display("FAIL idle_quiet: got start=%b gnt=%b busy=%b id=%0d expected all 0",
                                   tx_start, gnt, sched_busy, cur_id);
            end
        end
    endtask

    task automatic test_single();
        logic [6:0] exp_c[$];
        bit seen = 0;
        clear_logs();
        busy_min = 2780; busy_var = 0;
        for (int i = 0; i < MW; i++) msg[i] = 1'($urandom_range(0, 1));
        msg[(2*MSG_LEN+0)*7 +: 7] = 7'h31;
        msg[(2*MSG_LEN+1)*7 +: 7] = 7'h35;
        exp_c = '{7'h31, 7'h35, 7'h0D};
        req = 4'b0100;
        @(negedge clk);
        n_tests++;
        if (gnt !== 4'b0100 || cur_id !== 3'd2 || sched_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_grant: got gnt=%b id=%0d busy=%b expected 0100/2/1", gnt, cur_id, sched_busy);
        end
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1;
                n_tests++;
                if (done !== 4'b0100 || gnt !== 4'b0000) begin
                    n_fail++; $display("FAIL single_done: got done=%b gnt=%b expected 0100/0000", done, gnt);
                end
            end
        end
        req = '0;
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL single_timeout: got no done expected done[2]"); end
        repeat (6) @(negedge clk);
        n_tests++;
        if (q_chars.size() != 3) begin
            n_fail++; $display("FAIL single_nchars: got %0d expected 3", q_chars.size());
        end else begin
            foreach (exp_c[i]) begin
                n_tests++;
                if (q_chars[i] !== exp_c[i]) begin
                    n_fail++; $display("FAIL single_char%0d: got %h expected %h", i, q_chars[i], exp_c[i]);
                end
            end
        end
        n_tests++;
        if (q_done.size() != 1 || n_busy_viol != 0) begin
            n_fail++; $display("FAIL single_done_count: got dones=%0d busy_viol=%0d expected 1/0", q_done.size(), n_busy_viol);
        end
    endtask

    task automatic test_round_robin();
        int exp_o[$] = '{0, 1, 2, 3, 0};
        logic [6:0] exp_c[$];
        int nd = 0;
        pulse_reset();
        clear_logs();
        busy_min = 1; busy_var = 4;
        for (int i = 0; i < MW; i++) msg[i] = 1'($urandom_range(0, 1));
        foreach (exp_o[j]) begin
            for (int k = 0; k < MSG_LEN; k++) exp_c.push_back(msg[(exp_o[j]*MSG_LEN+k)*7 +: 7]);
            exp_c.push_back(7'h0D);
        end
        req = 4'b1111;
        for (int c = 0; c < 2000 && nd < 5; c++) begin
            @(negedge clk);
            if (done != '0) nd++;
        end
        req = '0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (q_gnt.size() != 5 || q_done.size() != 5) begin
            n_fail++; $display("FAIL rr_count: got grants=%0d dones=%0d expected 5/5", q_gnt.size(), q_done.size());
        end else begin
            foreach (exp_o[j]) begin
                n_tests++;
                if (q_gnt[j] != exp_o[j] || q_done[j] != exp_o[j]) begin
                    n_fail++; $display("FAIL rr_order%0d: got gnt=%0d done=%0d expected %0d", j, q_gnt[j], q_done[j], exp_o[j]);
                end
            end
        end
        n_tests++;
        if (q_chars != exp_c) begin
            n_fail++; $display("FAIL rr_chars: got %0d chars expected %0d matching", q_chars.size(), exp_c.size());
        end
        n_tests++;
        if (n_busy_viol != 0 || n_done_gnt != 0) begin
            n_fail++; $display("FAIL rr_protocol: got busy_viol=%0d done_with_gnt=%0d expected 0/0", n_busy_viol, n_done_gnt);
        end
    endtask

    task automatic test_snapshot();
        logic [6:0] exp_c[$] = '{7'h32, 7'h33, 7'h0D};
        bit seen = 0;
        clear_logs();
        msg[(1*MSG_LEN+0)*7 +: 7] = 7'h32;
        msg[(1*MSG_LEN+1)*7 +: 7] = 7'h33;
        req = 4'b0010;
        for (int c = 0; c < 50 && gnt == '0; c++) @(negedge clk);
        n_tests++;
        if (gnt !== 4'b0010) begin n_fail++; $display("FAIL snap_grant: got %b expected 0010", gnt); end
        @(negedge clk);
        msg[(1*MSG_LEN+0)*7 +: 7] = 7'h39;
        msg[(1*MSG_LEN+1)*7 +: 7] = 7'h39;
        req = '0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (done != '0) seen = 1;
        end
        n_tests++;
        if (!seen || done !== 4'b0010) begin
            n_fail++; $display("FAIL snap_done: got seen=%0d done=%b expected 1/0010", seen, done);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (q_chars != exp_c) begin
            n_fail++; $display("FAIL snap_chars: got n=%0d first=%h expected 32 33 0d",
                               q_chars.size(), (q_chars.size() > 0) ? q_chars[0] : 7'h7F);
        end
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        int nd = 0;
        int exp_g[$] = '{2, 0, 3};
        int exp_d[$] = '{0, 3};
        clear_logs();
        busy_min = 3; busy_var = 2;
        req = 4'b0100;
        for (int c = 0; c < 500 && starts < 2; c++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        n_tests++;
        if (starts != 2) begin n_fail++; $display("FAIL mid_starts: got %0d expected 2", starts); end
        @(negedge clk);
        rst = 1'b1; req = '0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (tx_start !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000 || sched_busy !== 1'b0 || cur_id !== 3'd0) begin
                n_fail++; $display("FAIL mid_abort: got start=%b gnt=%b done=%b busy=%b id=%0d expected all 0",
                                   tx_start, gnt, done, sched_busy, cur_id);
            end
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (q_done.size() != 0 || q_chars.size() != 2) begin
            n_fail++; $display("FAIL mid_quiet: got dones=%0d chars=%0d expected 0/2", q_done.size(), q_chars.size());
        end
        req = 4'b1001;
        for (int c = 0; c < 1000 && req != '0; c++) begin
            @(negedge clk);
            if (done != '0) begin nd++; req = req & ~done; end
        end
        req = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (q_gnt != exp_g || q_done != exp_d) begin
            n_fail++; $display("FAIL mid_regrant: got grants=%0d dones=%0d first_after=%0d expected order 2,0,3 / 0,3",
                               q_gnt.size(), q_done.size(), (q_gnt.size() > 1) ? q_gnt[1] : -1);
        end
    endtask

    task automatic test_random();
        int m_ptr = 0;
        pulse_reset();
        busy_min = 1; busy_var = 5;
        for (int r = 0; r < 6; r++) begin
            logic [NREQ-1:0] mask, pend;
            int exp_o[$];
            logic [6:0] exp_c[$];
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < MW; i++) msg[i] = 1'($urandom_range(0, 1));
            pend = mask;
            while (pend != '0) begin
                int sel = -1;
                for (int k = 0; k < NREQ && sel < 0; k++) if (pend[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
                exp_o.push_back(sel);
                for (int k = 0; k < MSG_LEN; k++) exp_c.push_back(msg[(sel*MSG_LEN+k)*7 +: 7]);
                exp_c.push_back(7'h0D);
                pend[sel] = 1'b0;
                m_ptr = (sel + 1) % NREQ;
            end
            clear_logs();
            req = mask;
            for (int c = 0; c < 2000 && req != '0; c++) begin
                @(negedge clk);
                if (done != '0) req = req & ~done;
            end
            n_tests++;
            if (req != '0) begin n_fail++; $display("FAIL rand_timeout%0d: got req=%b expected 0000", r, req); end
            req = '0;
            repeat (3) @(negedge clk);
            n_tests++;
            if (q_gnt != exp_o || q_done != exp_o) begin
                n_fail++; $display("FAIL rand_order%0d: got grants=%0d first=%0d expected %0d first=%0d (mask %b)",
                                   r, q_gnt.size(), (q_gnt.size() > 0) ? q_gnt[0] : -1, exp_o.size(), exp_o[0], mask);
            end
            n_tests++;
            if (q_chars != exp_c) begin
                n_fail++; $display("FAIL rand_chars%0d: got %0d chars expected %0d matching", r, q_chars.size(), exp_c.size());
            end
        end
        n_tests++;
        if (n_busy_viol != 0 || n_done_gnt != 0) begin
            n_fail++; $display("FAIL rand_protocol: got busy_viol=%0d done_with_gnt=%0d expected 0/0", n_busy_viol, n_done_gnt);
        end
    endtask

    task automatic test_noterm();
        int starts = 0;
        logic [6:0] ch = 7'h7F;
        logic [NREQ-1:0] d = '0;
        for (int i = 0; i < 28; i++) msg6[i] = 1'($urandom_range(0, 1));
        msg6[6:0] = 7'h30;
        req6 = 4'b0001;
        for (int c = 0; c < 200 && d == '0; c++) begin
            @(negedge clk);
            if (tx_start6) begin starts++; ch = tx_data6; end
            d = done6;
        end
        req6 = '0;
        repeat (6) begin
            @(negedge clk);
            if (tx_start6) begin starts++; ch = tx_data6; end
        end
        n_tests++;
        if (starts != 1 || ch !== 7'h30) begin
            n_fail++; $display("FAIL noterm_chars: got starts=%0d last=%h expected 1/30", starts, ch);
        end
        n_tests++;
        if (d !== 4'b0001) begin n_fail++; $display("FAIL noterm_done: got %b expected 0001", d); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_snapshot();
        test_reset_mid();
        test_random();
        test_noterm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
